// File: rtl/clocks_pkg.sv
// ---------------------------------------------------------------------------
// clocks_pkg
//   Shared constants for the clock divider bank.
//   - DIV_W_DFLT    : default counter/divisor width per channel
//   - DIV_*         : named divisors (tick periods in master_clk cycles,
//                     assuming a 100 MHz master_clk)
//   - SIM_SHIFT_SIM : divisor right-shift used by simulation benches
// ---------------------------------------------------------------------------
package clocks_pkg;

    localparam int unsigned DIV_W_DFLT = 28;

    // All values fit in 28 bits (max 2^28-1 = 268,435,455).
    localparam int unsigned DIV_FAST   = 100_000;      // 1 kHz display mux
    localparam int unsigned DIV_BLINK  = 40_000_000;   // 2.5 Hz blink
    localparam int unsigned DIV_1HZ    = 100_000_000;  // 1 Hz game timer
    localparam int unsigned DIV_2HZ    = 50_000_000;   // 2 Hz game timer
    localparam int unsigned DIV_ADJUST = 25_000_000;   // 4 Hz setting adjust

    localparam int unsigned SIM_SHIFT_SIM = 7;

    typedef logic [DIV_W_DFLT-1:0] div_t;

endpackage

// File: rtl/clk_div_channel.sv
// ---------------------------------------------------------------------------
// clk_div_channel
//   One divider channel: counter, active/shadow divisor pair, pending flag,
//   registered 50%-duty clock and single-cycle terminal-count tick.
//
//   master_clk : system clock, rising edge
//   rst        : asynchronous active-low reset
//   en         : count enable
//   restart    : synchronous restart strobe (highest priority)
//   div_wr     : divisor write strobe
//   div_in     : divisor value written on div_wr
//   clk_out    : divided clock, toggles at each terminal count
//   tick       : one-cycle pulse at each terminal count
//   pending    : written divisor not yet applied
// ---------------------------------------------------------------------------
module clk_div_channel
    import clocks_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DFLT,
    parameter int unsigned DEFAULT_DIV = DIV_FAST,
    parameter int unsigned SIM_SHIFT   = 0
) (
    input  logic             master_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [DIV_W-1:0] ONE     = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] term;
    logic             at_term;

    // A divisor of 0 (or one shifted down to 0) would never reach a terminal
    // count, so clamp to 1: tick every cycle, clk_out toggles every cycle.
    always_comb begin
        term = active >> SIM_SHIFT;
        if (term == '0) begin
            term = ONE;
        end
    end

    assign at_term = (cnt == (term - ONE));

    // The active divisor only changes at a terminal count or restart, so the
    // period in progress is never shortened or stretched by a write.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            active  <= DEF_DIV;
            shadow  <= DEF_DIV;
        end else if (restart) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            active  <= div_wr ? div_in : shadow;
            if (div_wr) begin
                shadow <= div_in;
            end
        end else if (!en) begin
            tick <= 1'b0;
            if (div_wr) begin
                shadow  <= div_in;
                pending <= 1'b1;
            end
        end else if (at_term) begin
            cnt     <= '0;
            tick    <= 1'b1;
            clk_out <= ~clk_out;
            pending <= 1'b0;
            active  <= div_wr ? div_in : shadow;
            if (div_wr) begin
                shadow <= div_in;
            end
        end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
            if (div_wr) begin
                shadow  <= div_in;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
//   Bank of N independent clock dividers driven from master_clk.
//
//   master_clk : system clock, rising edge
//   rst        : asynchronous active-low reset
//   en         : [N]        per-channel count enable
//   restart    : [N]        per-channel synchronous restart strobe
//   div_wr     : [N]        per-channel divisor write strobe
//   div_in     : [N*DIV_W]  packed divisors, channel i at [i*DIV_W +: DIV_W]
//   clk_out    : [N]        divided clocks (50% duty)
//   tick       : [N]        one-cycle pulse at each terminal count
//   pending    : [N]        written divisor not yet applied
// ---------------------------------------------------------------------------
module clk_div_bank
    import clocks_pkg::*;
#(
    parameter int unsigned N           = 2,
    parameter int unsigned DIV_W       = DIV_W_DFLT,
    parameter int unsigned DEFAULT_DIV = DIV_FAST,
    parameter int unsigned SIM_SHIFT   = 0
) (
    input  logic               master_clk,
    input  logic               rst,
    input  logic [N-1:0]       en,
    input  logic [N-1:0]       restart,
    input  logic [N-1:0]       div_wr,
    input  logic [N*DIV_W-1:0] div_in,
    output logic [N-1:0]       clk_out,
    output logic [N-1:0]       tick,
    output logic [N-1:0]       pending
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .SIM_SHIFT   (SIM_SHIFT)
        ) u_ch (
            .master_clk (master_clk),
            .rst        (rst),
            .en         (en[i]),
            .restart    (restart[i]),
            .div_wr     (div_wr[i]),
            .div_in     (div_in[i*DIV_W +: DIV_W]),
            .clk_out    (clk_out[i]),
            .tick       (tick[i]),
            .pending    (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

    logic        master_clk;
    logic        rst;
    logic [1:0]  en;
    logic [1:0]  restart;
    logic [1:0]  div_wr;
    logic [15:0] div_in;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  pending;
    logic [1:0]  s_clk_out;
    logic [1:0]  s_tick;
    logic [1:0]  s_pending;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_bank #(
        .N(2), .DIV_W(8), .DEFAULT_DIV(4), .SIM_SHIFT(0)
    ) dut (
        .master_clk (master_clk),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .div_wr     (div_wr),
        .div_in     (div_in),
        .clk_out    (clk_out),
        .tick       (tick),
        .pending    (pending)
    );

    // Shifted variant: 16 >> 2 = 4 cycle tick period.
    clk_div_bank #(
        .N(2), .DIV_W(8), .DEFAULT_DIV(16), .SIM_SHIFT(2)
    ) dut_s (
        .master_clk (master_clk),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .div_wr     (div_wr),
        .div_in     (div_in),
        .clk_out    (s_clk_out),
        .tick       (s_tick),
        .pending    (s_pending)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, elapsed %0t required < 200000", $time);
        $fatal(1, "timeout");
    end

    // One rising edge, then settle before sampling.
    task automatic cyc();
        @(posedge master_clk);
        #1;
    endtask

    // Hold reset, then release between edges; edge 1 is the next posedge.
    task automatic do_reset(input logic [1:0] en_val);
        rst     = 1'b0;
        restart = 2'b00;
        div_wr  = 2'b00;
        div_in  = 16'h0000;
        en      = en_val;
        #3;
        @(negedge master_clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 2'b00; restart = 2'b00; div_wr = 2'b00; div_in = 16'h0;
        #12;
        n_checks++;
        if ({clk_out, tick, pending} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got clk_out=%b tick=%b pending=%b, want all 0", clk_out, tick, pending);
        end
    endtask

    task automatic test_basic();
        logic [1:0] et, ec;
        do_reset(2'b11);
        for (int e = 1; e <= 12; e++) begin
            cyc();
            et = (e % 4 == 0) ? 2'b11 : 2'b00;
            ec = (((e / 4) % 2) == 1) ? 2'b11 : 2'b00;
            n_checks++;
            if (tick !== et) begin
                n_fail++;
                $display("FAIL basic_tick edge %0d: got %b want %b", e, tick, et);
            end
            n_checks++;
            if (clk_out !== ec) begin
                n_fail++;
                $display("FAIL basic_clk edge %0d: got %b want %b", e, clk_out, ec);
            end
        end
    endtask

    task automatic test_div_change();
        logic et0, et1, ep0;
        do_reset(2'b11);
        for (int e = 1; e <= 10; e++) begin
            if (e == 2) begin
                div_wr = 2'b01;
                div_in = {8'd7, 8'd2};
            end else begin
                div_wr = 2'b00;
            end
            cyc();
            et0 = (e == 4 || e == 6 || e == 8 || e == 10);
            et1 = (e == 4 || e == 8);
            ep0 = (e == 2 || e == 3);
            n_checks++;
            if (tick !== {et1, et0}) begin
                n_fail++;
                $display("FAIL divchg_tick edge %0d: got %b want %b", e, tick, {et1, et0});
            end
            n_checks++;
            if (pending !== {1'b0, ep0}) begin
                n_fail++;
                $display("FAIL divchg_pending edge %0d: got %b want %b", e, pending, {1'b0, ep0});
            end
        end
    endtask

    task automatic test_div_zero();
        logic et0, ec0;
        do_reset(2'b11);
        div_wr = 2'b01;
        div_in = 16'h0000;
        for (int e = 1; e <= 8; e++) begin
            cyc();
            div_wr = 2'b00;
            et0 = (e >= 4);
            ec0 = (e >= 4) && (((e - 3) % 2) == 1);
            n_checks++;
            if (tick[0] !== et0) begin
                n_fail++;
                $display("FAIL divzero_tick edge %0d: got %b want %b", e, tick[0], et0);
            end
            n_checks++;
            if (clk_out[0] !== ec0) begin
                n_fail++;
                $display("FAIL divzero_clk edge %0d: got %b want %b", e, clk_out[0], ec0);
            end
        end
    endtask

    task automatic test_enable();
        logic et0, ec0, et1;
        do_reset(2'b11);
        for (int e = 1; e <= 8; e++) begin
            en = (e >= 3 && e <= 5) ? 2'b10 : 2'b11;
            cyc();
            et0 = (e == 7);
            ec0 = (e >= 7);
            et1 = (e == 4 || e == 8);
            n_checks++;
            if (tick !== {et1, et0}) begin
                n_fail++;
                $display("FAIL enable_tick edge %0d: got %b want %b", e, tick, {et1, et0});
            end
            n_checks++;
            if (clk_out[0] !== ec0) begin
                n_fail++;
                $display("FAIL enable_clk edge %0d: got %b want %b", e, clk_out[0], ec0);
            end
        end
    endtask

    task automatic test_restart();
        logic et0, ec0, et1, ec1;
        do_reset(2'b11);
        for (int e = 1; e <= 12; e++) begin
            if (e == 6) begin
                restart = 2'b01;
                div_wr  = 2'b01;
                div_in  = {8'd9, 8'd3};
            end else begin
                restart = 2'b00;
                div_wr  = 2'b00;
            end
            cyc();
            if (e >= 6) begin
                et0 = (e == 9 || e == 12);
                ec0 = (e >= 9 && e < 12);
                et1 = (e == 8 || e == 12);
                ec1 = (e < 8 || e >= 12);
                n_checks++;
                if (tick !== {et1, et0}) begin
                    n_fail++;
                    $display("FAIL restart_tick edge %0d: got %b want %b", e, tick, {et1, et0});
                end
                n_checks++;
                if (clk_out !== {ec1, ec0}) begin
                    n_fail++;
                    $display("FAIL restart_clk edge %0d: got %b want %b", e, clk_out, {ec1, ec0});
                end
                n_checks++;
                if (pending !== 2'b00) begin
                    n_fail++;
                    $display("FAIL restart_pending edge %0d: got %b want 00", e, pending);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(2'b11);
        for (int e = 1; e <= 4; e++) begin
            if (e == 4) begin
                div_wr = 2'b01;
                div_in = {8'd0, 8'd2};
                en     = 2'b10;
            end
            cyc();
        end
        div_wr = 2'b00;
        n_checks++;
        if ({pending[0], tick[1], clk_out[1]} !== 3'b111) begin
            n_fail++;
            $display("FAIL arst_pre: got pending0=%b tick1=%b clk1=%b want 1 1 1", pending[0], tick[1], clk_out[1]);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({clk_out, tick, pending} !== 6'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got clk_out=%b tick=%b pending=%b want all 0", clk_out, tick, pending);
        end
        // Pending divisor of 2 must have been discarded: default period 4.
        en = 2'b11;
        @(negedge master_clk);
        rst = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            cyc();
            n_checks++;
            if (tick[0] !== (e == 4)) begin
                n_fail++;
                $display("FAIL arst_discard edge %0d: got %b want %b", e, tick[0], (e == 4));
            end
        end
    endtask

    task automatic test_sim_shift();
        logic et0, et1;
        do_reset(2'b11);
        div_wr = 2'b01;
        div_in = {8'd0, 8'd3};  // 3 >> 2 = 0, clamps to 1
        for (int e = 1; e <= 8; e++) begin
            cyc();
            div_wr = 2'b00;
            et0 = (e >= 4);
            et1 = (e == 4 || e == 8);
            n_checks++;
            if (s_tick !== {et1, et0}) begin
                n_fail++;
                $display("FAIL shift_tick edge %0d: got %b want %b", e, s_tick, {et1, et0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_change();
        test_div_zero();
        test_enable();
        test_restart();
        test_async_reset();
        test_sim_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
Parametrised bank of N independent clock dividers, all driven from master_clk. It is the successor to the fixed fast/blink divider pair in the whackamole design.
- Each channel produces a 50%-duty divided clock and a single-cycle tick, both registered.
- Each channel's divisor is runtime-programmable. A new divisor is applied glitch-free at the next terminal count.
- A SIM_SHIFT parameter replaces the hand-edited simulation cutoffs.
- Feeds the display multiplexer, blink logic and game-speed timers.

Parameters:
N, 2, number of divider channels
DIV_W, 28, width of counter and divisor per channel
DEFAULT_DIV, 100000, reset value of active and pending divisor, all channels
SIM_SHIFT, 0, effective divisor = div >> SIM_SHIFT (simulation speed-up; 0 for synthesis)

Ports:
master_clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
en  input  N  per-channel count enable
restart  input  N  per-channel synchronous restart strobe
div_wr  input  N  per-channel divisor write strobe
div_in  input  N*DIV_W  packed divisors; channel i at [i*DIV_W +: DIV_W]
clk_out  output  N  divided clock, toggles each terminal count
tick  output  N  one master_clk-cycle pulse at each terminal count
pending  output  N  1 = written divisor not yet applied

Behaviour:
- Reset (rst=0, asynchronous, no clock edge needed):
  - cnt=0, clk_out=0, tick=0, pending=0.
  - active=DEFAULT_DIV, shadow=DEFAULT_DIV.
- Terminal value: term = max(active >> SIM_SHIFT, 1). Divisor 0 or shifted-to-0 clamps to 1.
- Per channel, each rising edge, priority highest first:
  1. restart=1:
     - cnt=0, clk_out=0, tick=0, pending=0.
     - active = div_wr ? div_in slice : shadow.
     - shadow updated if div_wr.
  2. en=0: cnt and clk_out hold, tick=0. div_wr still updates shadow and sets pending=1.
  3. en=1 and cnt==term-1 (terminal):
     - cnt=0, tick=1, clk_out toggles.
     - active = div_wr ? div_in slice : shadow.
     - shadow updated if div_wr; pending=0.
  4. en=1 otherwise: cnt=cnt+1, tick=0. div_wr writes shadow and sets pending=1.
- Output timing:
  - tick period = term cycles; clk_out period = 2*term cycles; duty exactly 50%.
  - All outputs are registered. First tick is high after the term-th enabled edge following reset release.
- Divisor changes never shorten or stretch the period in progress. They take effect from the next period.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- Counter arithmetic is unsigned DIV_W bits. cnt never exceeds term-1, so wrap is impossible.
- Reset mid-period discards any pending divisor.

Decomposition:
- Package clocks_pkg holds:
  - DIV_W default.
  - Named divisor constants: DIV_FAST=100000, DIV_BLINK=40000000, DIV_1HZ, DIV_2HZ, DIV_ADJUST.
  - SIM_SHIFT_SIM=7 for benches.
- Sub-module clk_div_channel contains one channel's counter, active/shadow registers, pending flag and outputs. It is instantiated N times in a generate loop.
- The top level only slices div_in and concatenates outputs.

Test Plan:
(All scenarios use N=2, DIV_W=8, DEFAULT_DIV=4, SIM_SHIFT=0 unless noted.)
1. Release rst, en=2'b11 -> tick[0] high after edges 4, 8, 12. clk_out[0] rises at edge 4, falls at 8. Both channels identical.
2. At edge 2, div_wr[0]=1, div_in[7:0]=2 -> pending[0]=1 until edge 4. Then ticks at edges 6, 8, 10; channel 1 unaffected.
3. Write divisor 0 to ch0 -> after the current period, clk_out[0] toggles every cycle and tick[0] stays high continuously.
4. en[0]=0 for 3 cycles starting after edge 2 -> cnt frozen at 2, tick[0] at edge 7 instead of 4. clk_out[0] holds its level while disabled.
5. restart[0] and div_wr[0] (value 3) in the same cycle mid-period -> next edge: clk_out[0]=0, cnt=0, pending=0. Then ticks every 3 cycles.
6. Assert rst low between edges mid-period -> clk_out, tick and pending are 0 immediately. Separately, SIM_SHIFT=2 with DEFAULT_DIV=16 -> tick every 4 cycles.
